// File: rtl/hazard_forward_unit.sv
// EX-stage operand-forwarding selects and load-use stall detection, driven by a
// private shadow of the EX/MEM/WB destination-register info fed from decode.
module hazard_forward_unit #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic [REG_W-1:0] id_wreg,
    input  logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             uses_rs;
        logic             uses_rt;
        logic             regwrite;
        logic             memread;
        logic [REG_W-1:0] wreg;
    } rec_t;

    rec_t             id_rec;
    rec_t             ex_q, ex_d;
    rec_t             mem_q, wb_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // A producer matches when it is live, writes a non-zero register equal to src.
    function automatic logic hit(input rec_t p, input logic [REG_W-1:0] src);
        return p.valid && p.regwrite && (p.wreg != '0) && (p.wreg == src);
    endfunction

    // A matching load in MEM yields 00: its data is not ready yet.
    function automatic logic [1:0] sel(input logic use_op, input logic [REG_W-1:0] src,
                                       input rec_t m, input rec_t w);
        logic [1:0] s;
        s = 2'b00;
        if (use_op) begin
            if (hit(m, src))      s = m.memread ? 2'b00 : 2'b10;
            else if (hit(w, src)) s = 2'b01;
        end
        return s;
    endfunction

    always_comb begin
        id_rec          = '0;
        id_rec.valid    = id_valid;
        id_rec.rs       = id_rs;
        id_rec.rt       = id_rt;
        id_rec.uses_rs  = id_uses_rs;
        id_rec.uses_rt  = id_uses_rt;
        id_rec.regwrite = id_regwrite;
        id_rec.memread  = id_memread;
        id_rec.wreg     = id_wreg;
    end

    always_comb begin
        stall = ex_q.valid && ex_q.memread && ex_q.regwrite && (ex_q.wreg != '0) && id_valid &&
                ((id_uses_rs && (id_rs == ex_q.wreg)) || (id_uses_rt && (id_rt == ex_q.wreg)));
        ex_d  = (flush || stall) ? rec_t'('0) : id_rec;
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_a     = sel(ex_q.valid && ex_q.uses_rs, ex_q.rs, mem_q, wb_q);
    assign fwd_b     = sel(ex_q.valid && ex_q.uses_rt, ex_q.rt, mem_q, wb_q);
    assign stall_cnt = stall_cnt_q;

    // Source-side fields of the older records are carried for visibility only.
    logic unused_fields;
    assign unused_fields = ^{mem_q.rs, mem_q.rt, mem_q.uses_rs, mem_q.uses_rt,
                             wb_q.rs, wb_q.rt, wb_q.uses_rs, wb_q.uses_rt, wb_q.memread};

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed checks of forwarding selects, load-use stall, flush and stall counter.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread, flush;
    logic [4:0]  id_rs, id_rt, id_wreg;
    logic [1:0]  fwd_a, fwd_b, s_fwd_a, s_fwd_b;
    logic        stall, s_stall;
    logic [15:0] stall_cnt;
    logic [3:0]  s_stall_cnt;
    int          n_tests = 0;
    int          n_fail = 0;

    hazard_forward_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_wreg(id_wreg), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .stall_cnt(stall_cnt)
    );

    hazard_forward_unit #(.REG_W(5), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_wreg(id_wreg), .flush(flush),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall(s_stall), .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic rw, input logic mr,
                         input logic [4:0] wr);
        id_valid = v;  id_rs = rs;  id_rt = rt;  id_uses_rs = urs;  id_uses_rt = urt;
        id_regwrite = rw;  id_memread = mr;  id_wreg = wr;
        #1;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic drain();
        nop();
        repeat (3) step();
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 5'($urandom));
            if (k == 0) begin
                rst_n = 1'b0;
                #1;
            end else step();
            n_tests++;
            if ({fwd_a, fwd_b, stall} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_outs: got fwd_a=%b fwd_b=%b stall=%b, want 00 00 0", fwd_a, fwd_b, stall);
            end
            n_tests++;
            if (stall_cnt !== 16'd0 || s_stall_cnt !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_cnt: got %0d/%0d, want 0/0", stall_cnt, s_stall_cnt);
            end
        end
        nop();
        rst_n = 1'b1;
        #1;
        n_tests++;
        if ({fwd_a, fwd_b, stall, stall_cnt} !== 21'b0) begin
            n_fail++;
            $display("FAIL reset_release: got %b %b %b %0d, want 00 00 0 0", fwd_a, fwd_b, stall, stall_cnt);
        end
        drain();
    endtask

    task automatic test_ex_mem();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);   // add r3
        step();
        drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6);   // sub r6, r3, r4
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL exmem_nostall: got stall=%b, want 0", stall);
        end
        step();
        n_tests++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
            n_fail++;
            $display("FAIL exmem_fwd: got %b %b, want 10 00", fwd_a, fwd_b);
        end
        drain();
    endtask

    task automatic test_mem_wb();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5);   // add r5
        step();
        nop();
        step();
        drive(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);   // or r8, r5, r7
        step();
        n_tests++;
        if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
            n_fail++;
            $display("FAIL memwb_fwd: got %b %b, want 01 00", fwd_a, fwd_b);
        end
        drain();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5);
        step();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5);
        step();
        drive(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd8);
        step();
        n_tests++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
            n_fail++;
            $display("FAIL mem_priority: got %b %b, want 10 00", fwd_a, fwd_b);
        end
        drain();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd5);   // add r5
        step();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6);   // add r6
        step();
        drive(1'b1, 5'd6, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 5'd9);   // or r9, r6, r5
        step();
        n_tests++;
        if (fwd_a !== 2'b10 || fwd_b !== 2'b01) begin
            n_fail++;
            $display("FAIL split_fwd: got %b %b, want 10 01", fwd_a, fwd_b);
        end
        drain();
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);   // lw r2
        step();
        drive(1'b1, 5'd3, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);   // add r4, r3, r2
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_stall: got stall=%b, want 1", stall);
        end
        step();
        n_tests++;
        if (stall !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL lu_bubble: got stall=%b fwd=%b%b cnt=%0d, want 0 0000 1", stall, fwd_a, fwd_b, stall_cnt);
        end
        step();
        n_tests++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b01 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL lu_fwd: got %b %b stall=%b, want 00 01 0", fwd_a, fwd_b, stall);
        end
        drain();
    endtask

    task automatic test_reg0_flush();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0);   // add r0
        step();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7);
        step();
        n_tests++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            n_fail++;
            $display("FAIL r0_fwd: got %b %b, want 00 00", fwd_a, fwd_b);
        end
        drain();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0);   // lw r0
        step();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd7);
        n_tests++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_nostall: got stall=%b, want 0", stall);
        end
        drain();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3);   // add r3
        step();
        drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        nop();
        n_tests++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_bubble: got %b %b, want 00 00", fwd_a, fwd_b);
        end
        drain();
        drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);   // lw r2
        step();
        drive(1'b1, 5'd3, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        flush = 1'b1;
        #1;
        n_tests++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_stall: got stall=%b, want 1", stall);
        end
        step();
        flush = 1'b0;
        nop();
        n_tests++;
        if (stall_cnt !== 16'd2 || fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_cnt: got cnt=%0d fwd=%b%b, want 2 0000", stall_cnt, fwd_a, fwd_b);
        end
        step();
        n_tests++;
        if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_nofwd: got %b %b stall=%b, want 00 00 0", fwd_a, fwd_b, stall);
        end
        drain();
    endtask

    task automatic test_saturation();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);   // lw r2, (r2)
        repeat (40) step();
        nop();
        step();
        n_tests++;
        if (s_stall_cnt !== 4'd15) begin
            n_fail++;
            $display("FAIL sat_cnt: got %0d, want 15", s_stall_cnt);
        end
        n_tests++;
        if (stall_cnt !== 16'd22) begin
            n_fail++;
            $display("FAIL wide_cnt: got %0d, want 22", stall_cnt);
        end
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
        repeat (4) step();
        drain();
        n_tests++;
        if (s_stall_cnt !== 4'd15 || stall_cnt !== 16'd24) begin
            n_fail++;
            $display("FAIL sat_hold: got %0d/%0d, want 15/24", s_stall_cnt, stall_cnt);
        end
    endtask

    initial begin
        flush = 1'b0;
        nop();
        repeat (2) step();
        rst_n = 1'b1;
        drain();
        test_reset();
        test_ex_mem();
        test_mem_wb();
        test_load_use();
        test_reg0_flush();
        test_saturation();
        test_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Generates the 2-bit operand-forwarding selects driven into the EX-stage forwarding muxes: 00 = register-file operand, 01 = WB write data, 10 = MEM ALU result; 11 is never driven.
- Keeps its own shadow pipeline of destination-register info (EX, MEM, WB) fed from decode.
- Raises a one-cycle load-use stall and inserts the bubble itself.
- Counts stall cycles for performance monitoring.

Parameters:
- REG_W, 5, register-index width.
- CNT_W, 16, stall-counter width.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID stage holds a real instruction.
- id_rs  input  REG_W  ID source register A.
- id_rt  input  REG_W  ID source register B.
- id_uses_rs  input  1  ID instruction reads rs.
- id_uses_rt  input  1  ID instruction reads rt.
- id_regwrite  input  1  ID instruction writes a register.
- id_memread  input  1  ID instruction is a load.
- id_wreg  input  REG_W  ID destination register.
- flush  input  1  taken branch/jump; the ID instruction must not enter EX.
- fwd_a  output  2  select for EX operand A.
- fwd_b  output  2  select for EX operand B.
- stall  output  1  hold PC and IF/ID this cycle.
- stall_cnt  output  CNT_W  saturating count of stall cycles.

Behaviour:
- State: three records EX, MEM, WB. Each record holds valid, rs, rt, uses_rs, uses_rt, regwrite, memread, wreg.
- Reset (async, rst_n low):
  - All record fields clear to 0.
  - stall_cnt = 0.
  - fwd_a = fwd_b = 00 and stall = 0, because the outputs are combinational from cleared state.
- Every rising edge, with no stall and no flush:
  - WB <= MEM, MEM <= EX (unconditional).
  - EX <= ID inputs.
- Stall:
  - Condition: EX.valid & EX.memread & EX.regwrite & EX.wreg != 0 & id_valid, AND either (id_uses_rs & id_rs == EX.wreg) or (id_uses_rt & id_rt == EX.wreg).
  - Combinational from current state and ID inputs; asserted in the same cycle.
  - While stall = 1, the next edge loads EX with a bubble (all zero). MEM and WB still shift.
  - Upstream holds the ID inputs stable.
  - The stall lasts exactly one cycle per load-use pair. After the bubble, the load sits in MEM and the dependency resolves through WB forwarding.
- Flush:
  - The next edge loads EX with a bubble; MEM and WB shift.
  - Flush has priority over stall. With flush and stall together, stall is still asserted and counted, and EX gets a bubble.
- Forwarding (combinational from records), rule for fwd_a:
  - If EX.valid & EX.uses_rs, then:
    - 10 when MEM.valid & MEM.regwrite & MEM.wreg != 0 & MEM.wreg == EX.rs;
    - otherwise 01 when the same conditions hold with WB in place of MEM;
    - otherwise 00.
  - If not EX.valid or not EX.uses_rs: 00.
  - fwd_b: identical rule using rt and uses_rt.
  - MEM has priority over WB (youngest producer wins).
  - Register 0 never forwards.
  - A MEM-stage load is never selected with 10. A load in MEM that matches gives 00 for that operand. The stall above guarantees this case cannot arise for valid code.
- stall_cnt increments by 1 on each edge where stall = 1 and saturates at all-ones.
- Reset asserted mid-operation clears all records immediately. In-flight forwarding and stall deassert asynchronously.

Test Plan:
1. Reset: pulse rst_n low with random inputs -> fwd_a = fwd_b = 00, stall = 0, stall_cnt = 0 while low and after release.
2. EX/MEM forward: issue add r3 (regwrite, wreg = 3), then sub using rs = 3, rt = 4 -> in the sub's EX cycle fwd_a = 10, fwd_b = 00.
3. MEM/WB forward and priority:
   - add r5, nop, then or using rs = 5 -> fwd_a = 01.
   - add r5, add r5, then or using rs = 5 -> fwd_a = 10.
4. Load-use: lw r2 (memread, wreg = 2), then add using rt = 2 -> stall = 1 for exactly one cycle with ID held; next cycle EX is a bubble; the add then reaches EX with fwd_b = 01; stall_cnt = 1.
5. Register 0 and flush:
   - add writing r0, then a user of r0 -> fwd = 00.
   - flush with lw r2 in EX and a dependent add in ID -> stall = 1, stall_cnt increments, EX gets a bubble, no forward.
6. Saturation: with CNT_W = 4, force 20 stall cycles -> stall_cnt = 15 and holds.
